// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// writeback_arbiter : ALU/MEM writeback queues, round-robin register-file
//                     write port and RAW scoreboard.          Rev 1.0
// ============================================================================
module writeback_arbiter #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [4:0]        alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [4:0]        mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              issue_valid,
  input  logic [4:0]        issue_rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  output logic              stall,
  output logic              RegWrite,
  output logic [4:0]        rd,
  output logic [DATA_W-1:0] WriteData,
  output logic              idle
);

  localparam int   PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int   CNT_W   = PTR_W + 1;
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  logic [1:0]        in_valid;
  logic [4:0]        in_rd     [2];
  logic [DATA_W-1:0] in_data   [2];
  logic [1:0]        q_ready;
  logic [1:0]        push;
  logic [1:0]        pop;
  logic [1:0]        empty;
  logic [1:0]        eligible;
  logic [4:0]        head_rd   [2];
  logic [DATA_W-1:0] head_data [2];

  logic              grant_any;
  logic              grant_sel;
  logic              last_grant;
  logic [4:0]        sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic              sel_writes;
  logic [31:0]       busy;
  logic [31:0]       busy_next;

  assign in_valid   = {mem_valid, alu_valid};
  assign in_rd[0]   = alu_rd;
  assign in_rd[1]   = mem_rd;
  assign in_data[0] = alu_data;
  assign in_data[1] = mem_data;
  assign alu_ready  = q_ready[0];
  assign mem_ready  = q_ready[1];

  for (genvar q = 0; q < 2; q++) begin : g_queue
    logic [4:0]        store_rd   [DEPTH];
    logic [DATA_W-1:0] store_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              fresh;
    logic              full;

    assign full         = (count == CNT_W'(DEPTH));
    assign q_ready[q]   = !full && !reset;
    assign push[q]      = in_valid[q] && q_ready[q];
    assign empty[q]     = (count == '0);
    // An entry becomes grantable one edge after it was accepted, which
    // gives the two-edge accept-to-write latency.
    assign eligible[q]  = (count > CNT_W'(1)) || ((count == CNT_W'(1)) && !fresh);
    assign head_rd[q]   = store_rd[rd_ptr];
    assign head_data[q] = store_data[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        fresh  <= 1'b0;
      end else begin
        if (push[q]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[q])  rd_ptr <= rd_ptr + 1'b1;
        case ({push[q], pop[q]})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        fresh <= push[q];
      end
    end

    always_ff @(posedge clk) begin
      if (push[q]) begin
        store_rd[wr_ptr]   <= in_rd[q];
        store_data[wr_ptr] <= in_data[q];
      end
    end
  end

  always_comb begin
    grant_any = 1'b0;
    grant_sel = SRC_ALU;
    case (eligible)
      2'b01:   begin grant_any = 1'b1; grant_sel = SRC_ALU; end
      2'b10:   begin grant_any = 1'b1; grant_sel = SRC_MEM; end
      2'b11:   begin grant_any = 1'b1; grant_sel = !last_grant; end
      default: begin grant_any = 1'b0; grant_sel = SRC_ALU; end
    endcase
  end

  assign pop[0]     = grant_any && (grant_sel == SRC_ALU);
  assign pop[1]     = grant_any && (grant_sel == SRC_MEM);
  assign sel_rd     = (grant_sel == SRC_MEM) ? head_rd[1]   : head_rd[0];
  assign sel_data   = (grant_sel == SRC_MEM) ? head_data[1] : head_data[0];
  // x0 writes are consumed but never reach the register file.
  assign sel_writes = grant_any && (sel_rd != 5'd0);

  always_comb begin
    busy_next = busy;
    if (RegWrite) busy_next[rd] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0)) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWrite   <= 1'b0;
      rd         <= '0;
      WriteData  <= '0;
      last_grant <= SRC_MEM;
      busy       <= '0;
    end else begin
      RegWrite <= sel_writes;
      if (sel_writes) begin
        rd        <= sel_rd;
        WriteData <= sel_data;
      end
      if (grant_any) last_grant <= grant_sel;
      busy <= busy_next;
    end
  end

  assign stall = !reset && (busy[rs1] || busy[rs2]);
  assign idle  = (&empty) && !RegWrite;

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// tb_writeback_arbiter : directed table-driven bench for writeback_arbiter.
//                                                               Rev 1.0
// ============================================================================
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, issue_valid;
  logic [4:0]  alu_rd, mem_rd, issue_rd, rs1, rs2;
  logic [63:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, stall, RegWrite, idle;
  logic [4:0]  rd;
  logic [63:0] WriteData;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_arbiter #(.DATA_W(64), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
    .stall(stall), .RegWrite(RegWrite), .rd(rd), .WriteData(WriteData), .idle(idle)
  );

  typedef struct {
    logic        av;  logic [4:0] ard; logic [63:0] ad;
    logic        mv;  logic [4:0] mrd; logic [63:0] md;
    logic        iv;  logic [4:0] ird;
    logic [4:0]  r1;  logic [4:0] r2;
    logic        e_ar, e_mr, e_we;
    logic [4:0]  e_rd; logic [63:0] e_wd;
    logic        e_st, e_idle;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
      input logic av, input logic [4:0] ard, input logic [63:0] ad,
      input logic mv, input logic [4:0] mrd, input logic [63:0] md,
      input logic iv, input logic [4:0] ird, input logic [4:0] r1, input logic [4:0] r2,
      input logic e_ar, input logic e_mr, input logic e_we, input logic [4:0] e_rd,
      input logic [63:0] e_wd, input logic e_st, input logic e_idle);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad; v.mv = mv; v.mrd = mrd; v.md = md;
    v.iv = iv; v.ird = ird; v.r1 = r1; v.r2 = r2;
    v.e_ar = e_ar; v.e_mr = e_mr; v.e_we = e_we; v.e_rd = e_rd; v.e_wd = e_wd;
    v.e_st = e_st; v.e_idle = e_idle;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic clear_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //      av ard  ad      mv mrd md     iv ird r1 r2 | ar mr we rd  wd      st idle
    vecs.push_back(mk(1, 5,  64'hAA,   0, 0, 0,     1, 7, 0, 0,  1, 1, 0, 0,  64'h0,   0, 0));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0,     0, 0, 7, 0,  1, 1, 0, 0,  64'h0,   1, 0));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0,     0, 0, 7, 0,  1, 1, 1, 5,  64'hAA,  1, 0));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0,     0, 0, 7, 0,  1, 1, 0, 5,  64'hAA,  1, 1));
    vecs.push_back(mk(1, 7,  64'h77,   0, 0, 0,     0, 0, 7, 0,  1, 1, 0, 5,  64'hAA,  1, 0));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0,     0, 0, 7, 0,  1, 1, 0, 5,  64'hAA,  1, 0));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0,     0, 0, 7, 0,  1, 1, 1, 7,  64'h77,  1, 0));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0,     0, 0, 7, 0,  1, 1, 0, 7,  64'h77,  0, 1));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0,     1, 0, 0, 0,  1, 1, 0, 7,  64'h77,  0, 1));
    // tie with last grant = ALU: MEM goes first
    vecs.push_back(mk(1, 3,  64'h33,   1, 4, 64'h44, 0, 0, 0, 0, 1, 1, 0, 7,  64'h77,  0, 0));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0,     0, 0, 0, 0,  1, 1, 0, 7,  64'h77,  0, 0));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0,     0, 0, 0, 0,  1, 1, 1, 4,  64'h44,  0, 0));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0,     0, 0, 0, 0,  1, 1, 1, 3,  64'h33,  0, 0));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0,     0, 0, 0, 0,  1, 1, 0, 3,  64'h33,  0, 1));
    // rd=0 entry is consumed without a write
    vecs.push_back(mk(1, 0,  64'hDEAD, 0, 0, 0,     0, 0, 0, 0,  1, 1, 0, 3,  64'h33,  0, 0));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0,     0, 0, 0, 0,  1, 1, 0, 3,  64'h33,  0, 0));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0,     0, 0, 0, 0,  1, 1, 0, 3,  64'h33,  0, 1));
    // three back-to-back ALU pushes into a two-deep queue
    vecs.push_back(mk(1, 10, 64'h100,  0, 0, 0,     0, 0, 0, 0,  1, 1, 0, 3,  64'h33,  0, 0));
    vecs.push_back(mk(1, 11, 64'h101,  0, 0, 0,     0, 0, 0, 0,  0, 1, 0, 3,  64'h33,  0, 0));
    vecs.push_back(mk(1, 12, 64'h102,  0, 0, 0,     0, 0, 0, 0,  1, 1, 1, 10, 64'h100, 0, 0));
    vecs.push_back(mk(1, 12, 64'h102,  0, 0, 0,     0, 0, 0, 0,  1, 1, 1, 11, 64'h101, 0, 0));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0,     0, 0, 0, 0,  1, 1, 0, 11, 64'h101, 0, 0));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0,     0, 0, 0, 0,  1, 1, 1, 12, 64'h102, 0, 0));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0,     0, 0, 0, 0,  1, 1, 0, 12, 64'h102, 0, 1));
    // re-issue of rd=9 in the commit cycle keeps it busy
    vecs.push_back(mk(1, 9,  64'h99,   0, 0, 0,     1, 9, 0, 0,  1, 1, 0, 12, 64'h102, 0, 0));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0,     0, 0, 0, 9,  1, 1, 0, 12, 64'h102, 1, 0));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0,     0, 0, 0, 9,  1, 1, 1, 9,  64'h99,  1, 0));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0,     1, 9, 0, 9,  1, 1, 0, 9,  64'h99,  1, 1));
    vecs.push_back(mk(0, 0,  0,        0, 0, 0,     0, 0, 0, 9,  1, 1, 0, 9,  64'h99,  1, 1));

    clear_inputs();
    reset = 1'b1;
    #1;
    check("rst_alu_ready", 0, alu_ready, 0);
    check("rst_mem_ready", 0, mem_ready, 0);
    check("rst_RegWrite",  0, RegWrite, 0);
    check("rst_rd",        0, rd, 0);
    check("rst_WriteData", 0, WriteData, 0);
    check("rst_stall",     0, stall, 0);
    check("rst_idle",      0, idle, 1);
    cycle();
    cycle();
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].ad;
      mem_valid = vecs[i].mv; mem_rd = vecs[i].mrd; mem_data = vecs[i].md;
      issue_valid = vecs[i].iv; issue_rd = vecs[i].ird;
      rs1 = vecs[i].r1; rs2 = vecs[i].r2;
      cycle();
      check("alu_ready", i, alu_ready, vecs[i].e_ar);
      check("mem_ready", i, mem_ready, vecs[i].e_mr);
      check("RegWrite",  i, RegWrite,  vecs[i].e_we);
      check("rd",        i, rd,        vecs[i].e_rd);
      check("WriteData", i, WriteData, vecs[i].e_wd);
      check("stall",     i, stall,     vecs[i].e_st);
      check("idle",      i, idle,      vecs[i].e_idle);
    end

    // Asynchronous reset while both queues hold entries and a write is live.
    clear_inputs();
    rs2 = 9;
    alu_valid = 1; alu_rd = 20; alu_data = 64'h120;
    mem_valid = 1; mem_rd = 21; mem_data = 64'h121;
    cycle();
    alu_valid = 0; mem_valid = 0;
    cycle();
    cycle();
    check("pre_rst_RegWrite", 0, RegWrite, 1);
    check("pre_rst_rd",       0, rd, 21);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_RegWrite",  0, RegWrite, 0);
    check("mid_rst_idle",      0, idle, 1);
    check("mid_rst_rd",        0, rd, 0);
    check("mid_rst_WriteData", 0, WriteData, 0);
    check("mid_rst_alu_ready", 0, alu_ready, 0);
    check("mid_rst_mem_ready", 0, mem_ready, 0);
    check("mid_rst_stall",     0, stall, 0);
    cycle();
    reset = 1'b0;
    check("post_rst_stall", 0, stall, 0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("post_rst_RegWrite", k, RegWrite, 0);
      check("post_rst_idle",     k, idle, 1);
    end
    check("post_rst_alu_ready", 0, alu_ready, 1);

    // First tie after reset goes to ALU.
    alu_valid = 1; alu_rd = 3; alu_data = 64'h3;
    mem_valid = 1; mem_rd = 4; mem_data = 64'h4;
    cycle();
    alu_valid = 0; mem_valid = 0;
    cycle();
    check("tie_e1_RegWrite", 0, RegWrite, 0);
    cycle();
    check("tie_e2_RegWrite",  0, RegWrite, 1);
    check("tie_e2_rd",        0, rd, 3);
    check("tie_e2_WriteData", 0, WriteData, 64'h3);
    cycle();
    check("tie_e3_RegWrite",  0, RegWrite, 1);
    check("tie_e3_rd",        0, rd, 4);
    check("tie_e3_WriteData", 0, WriteData, 64'h4);
    cycle();
    check("tie_e4_RegWrite", 0, RegWrite, 0);
    check("tie_e4_idle",     0, idle, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
